// File: rtl/intercal_alu_pkg.sv
// rtl/intercal_alu_pkg.sv - opcode and FSM state types for the serial INTERCAL ALU
// Purpose: shared opcode encoding (op_t / OP_* constants) and FSM state enum.
// Ports: none (package).
package intercal_alu_pkg;

  typedef enum logic [2:0] {
    OP_MINGLE = 3'b000,
    OP_SELECT = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

endpackage

// File: rtl/intercal_alu_serial_if.sv
// rtl/intercal_alu_serial_if.sv - byte-serial load / byte-mux readout bundle of the ALU
// Purpose: groups the control, load and readout signals of intercal_alu_serial.
// Ports (slave view): ena, ld_a, ld_b, din[7:0], start, op[2:0], wide, out_sel in;
//                     dout[7:0], busy, done, err out.
interface intercal_alu_serial_if #(
  parameter int W = 16
);
  localparam int SW = $clog2(2 * W / 8);

  logic          ena;
  logic          ld_a;
  logic          ld_b;
  logic [7:0]    din;
  logic          start;
  logic [2:0]    op;
  logic          wide;
  logic [SW-1:0] out_sel;
  logic [7:0]    dout;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output ena, ld_a, ld_b, din, start, op, wide, out_sel,
    input  dout, busy, done, err
  );

  modport slave (
    input  ena, ld_a, ld_b, din, start, op, wide, out_sel,
    output dout, busy, done, err
  );
endinterface

// File: rtl/intercal_select_serial.sv
// rtl/intercal_select_serial.sv - bit-serial INTERCAL select engine
// Purpose: scans operand bits MSB to LSB, one per enabled cycle after go, and
//          appends A[i] to the right-justified result whenever B[i] is set.
// Ports: clk, rst_n, ena in; a, b [2W-1:0] in; wide, go in;
//        r [2W-1:0] out (result), last out (final bit processed this cycle).
module intercal_select_serial
  import intercal_alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           wide,
  input  logic           go,
  output logic [2*W-1:0] r,
  output logic           last
);
  localparam int IW = $clog2(2 * W);

  logic [2*W-1:0] r_q, r_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           act_q, act_d;

  always_comb begin
    r_d   = r_q;
    idx_d = idx_q;
    act_d = act_q;
    if (go) begin
      r_d   = '0;
      idx_d = wide ? IW'(2 * W - 1) : IW'(W - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      // Shifting left while scanning MSB first keeps the original bit order.
      if (b[idx_q]) r_d = {r_q[2*W-2:0], a[idx_q]};
      if (idx_q == '0) act_d = 1'b0;
      else             idx_d = idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
    end else if (ena) begin
      r_q   <= r_d;
      idx_q <= idx_d;
      act_q <= act_d;
    end
  end

  assign r    = r_q;
  assign last = act_q && (idx_q == '0);
endmodule

// File: rtl/intercal_alu_serial.sv
// rtl/intercal_alu_serial.sv - sequential INTERCAL ALU with byte-serial operands
// Purpose: operand shift registers, IDLE/RUN/FIN control, combinational
//          mingle and unary AND/OR/XOR, serial select, byte readout mux.
// Ports: clk, rst_n (sync, active-low) in; intf (slave modport) carries
//        ena/ld_a/ld_b/din/start/op/wide/out_sel in and dout/busy/done/err out.
module intercal_alu_serial
  import intercal_alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  intercal_alu_serial_if.slave intf
);
  localparam int W2 = 2 * W;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            wide_q, wide_d;
  logic [W2-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic            err_q, err_d;
  logic            sel_go, sel_last;
  logic [W2-1:0]   sel_r, r_out;
  logic [W2-1:0]   calc_r;
  logic            calc_err;
  logic [W-1:0]    an, an_rot;
  logic [W2-1:0]   aw_rot;
  logic            hi_a, hi_b;

  intercal_select_serial #(.W(W)) u_select (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (intf.ena),
    .a     (a_q),
    .b     (b_q),
    .wide  (intf.wide),
    .go    (sel_go),
    .r     (sel_r),
    .last  (sel_last)
  );

  assign an     = a_q[W-1:0];
  assign an_rot = {an[0], an[W-1:1]};
  assign aw_rot = {a_q[0], a_q[W2-1:1]};
  assign hi_a   = |a_q[W2-1:W];
  assign hi_b   = |b_q[W2-1:W];

  // Single-cycle results; operands are frozen while busy so RUN may evaluate them.
  always_comb begin
    calc_r   = '0;
    calc_err = 1'b0;
    case (op_q)
      OP_MINGLE: begin
        if (hi_a || hi_b) calc_err = 1'b1;
        else begin
          for (int i = 0; i < W; i++) begin
            calc_r[2*i+1] = a_q[i];
            calc_r[2*i]   = b_q[i];
          end
        end
      end
      OP_SELECT: calc_r = '0;
      OP_AND: calc_r = wide_q ? (a_q & aw_rot) : {{W{1'b0}}, an & an_rot};
      OP_OR:  calc_r = wide_q ? (a_q | aw_rot) : {{W{1'b0}}, an | an_rot};
      OP_XOR: calc_r = wide_q ? (a_q ^ aw_rot) : {{W{1'b0}}, an ^ an_rot};
      default: calc_err = 1'b1;
    endcase
    if ((op_q == OP_AND || op_q == OP_OR || op_q == OP_XOR) && !wide_q && hi_a) begin
      calc_err = 1'b1;
      calc_r   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wide_d  = wide_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    sel_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start takes priority; a load in the same cycle is dropped.
        if (intf.start) begin
          op_d    = intf.op;
          wide_d  = intf.wide;
          err_d   = 1'b0;
          sel_go  = (intf.op == OP_SELECT);
          state_d = ST_RUN;
        end else begin
          if (intf.ld_a) a_d = {a_q[W2-9:0], intf.din};
          if (intf.ld_b) b_d = {b_q[W2-9:0], intf.din};
        end
      end
      ST_RUN: begin
        if (op_q != OP_SELECT) begin
          res_d   = calc_r;
          err_d   = calc_err;
          state_d = ST_FIN;
        end else if (sel_last) begin
          state_d = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MINGLE;
      wide_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else if (intf.ena) begin
      state_q <= state_d;
      op_q    <= op_d;
      wide_q  <= wide_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Select keeps its result in the engine; other ops in res_q.
  assign r_out     = (op_q == OP_SELECT) ? sel_r : res_q;
  assign intf.dout = r_out[{intf.out_sel, 3'b000} +: 8];
  assign intf.busy = (state_q == ST_RUN);
  assign intf.done = (state_q == ST_FIN);
  assign intf.err  = err_q;
endmodule

// File: tb/tb_intercal_alu_serial.sv
// tb/tb_intercal_alu_serial.sv - self-checking bench for intercal_alu_serial
module tb_intercal_alu_serial;
  import intercal_alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intercal_alu_serial_if #(.W(W)) intf();
  intercal_alu_serial #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .intf(intf));

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] a_m, b_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_r(output logic [31:0] r);
    for (int k = 0; k < 4; k++) begin
      intf.out_sel = 2'(k);
      #1;
      r[8*k +: 8] = intf.dout;
    end
  endtask

  task automatic load(input bit to_b, input logic [31:0] v);
    for (int k = 3; k >= 0; k--) begin
      intf.din = v[8*k +: 8];
      if (to_b) intf.ld_b = 1'b1;
      else      intf.ld_a = 1'b1;
      tick();
      intf.ld_a = 1'b0;
      intf.ld_b = 1'b0;
    end
    if (to_b) b_m = v;
    else      a_m = v;
  endtask

  // Reference: results straight from the operator definitions.
  function automatic void model(input logic [2:0] op, input bit wide,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int n);
    int nb, k;
    logic [31:0] mask, x, rot;
    nb   = wide ? 32 : 16;
    mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    r = '0; e = 1'b0; n = 1;
    if (op == 3'd0) begin
      if ((a >> 16) != 0 || (b >> 16) != 0) e = 1'b1;
      else for (int i = 0; i < 16; i++) begin
        r[2*i+1] = a[i];
        r[2*i]   = b[i];
      end
    end else if (op == 3'd1) begin
      n = nb;
      k = 0;
      for (int i = 0; i < nb; i++)
        if (b[i]) begin
          r[k] = a[i];
          k++;
        end
    end else if (op <= 3'd4) begin
      x   = a & mask;
      rot = ((x >> 1) | (x << (nb - 1))) & mask;
      if (!wide && (a >> 16) != 0) e = 1'b1;
      else if (op == 3'd2) r = x & rot;
      else if (op == 3'd3) r = x | rot;
      else                 r = x ^ rot;
    end else begin
      e = 1'b1;
    end
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input bit wide,
                        input int gap, input bit poke,
                        output logic [31:0] r_got, output logic e_got);
    logic [31:0] r_exp;
    logic e_exp;
    int n, lat, busy_cnt;
    model(op, wide, a_m, b_m, r_exp, e_exp, n);
    intf.op = op;
    intf.wide = wide;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    intf.ld_a = 1'b0;
    intf.ld_b = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!intf.done && lat < 300) begin
      if (intf.busy) busy_cnt++;
      if (poke && lat == 2) begin
        intf.ld_b = 1'b1;
        intf.din = 8'hA5;
        intf.start = 1'b1;
        intf.op = 3'b000;
      end
      if (gap > 0 && lat == 3) intf.ena = 1'b0;
      if (gap > 0 && lat == 3 + gap) intf.ena = 1'b1;
      tick();
      lat++;
      intf.ld_b = 1'b0;
      intf.start = 1'b0;
    end
    intf.ena = 1'b1;
    chk({tag, ".latency"}, lat, n + 1 + gap);
    chk({tag, ".busy_cycles"}, busy_cnt, n + gap);
    chk({tag, ".busy_at_done"}, {31'b0, intf.busy}, 32'd0);
    read_r(r_got);
    e_got = intf.err;
    chk({tag, ".r"}, r_got, r_exp);
    chk({tag, ".err"}, {31'b0, e_got}, {31'b0, e_exp});
    tick();
    chk({tag, ".done_pulse"}, {31'b0, intf.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    bit seen;
    intf.ena = 1'b1; intf.ld_a = 1'b0; intf.ld_b = 1'b0; intf.din = '0;
    intf.start = 1'b0; intf.op = '0; intf.wide = 1'b0; intf.out_sel = '0;
    a_m = '0; b_m = '0;
    tick(); tick();
    rst_n = 1'b1;

    chk("reset.busy", {31'b0, intf.busy}, 0);
    chk("reset.done", {31'b0, intf.done}, 0);
    chk("reset.err", {31'b0, intf.err}, 0);
    read_r(r);
    chk("reset.r", r, 0);

    load(0, 32'h0000FFFF); load(1, 32'h0);
    run_op("mingle", OP_MINGLE, 0, 0, 0, r, e);
    chk("mingle.const", r, 32'hAAAAAAAA);

    load(0, 32'hF0F0F0F0); load(1, 32'hFF00FF00);
    run_op("sel_wide", OP_SELECT, 1, 0, 0, r, e);
    chk("sel_wide.const", r, 32'h0000F0F0);
    load(0, 32'h00F0); load(1, 32'h00FF);
    run_op("sel_narrow", OP_SELECT, 0, 0, 0, r, e);
    chk("sel_narrow.const", r, 32'h00F0);

    load(0, 32'h0005);
    run_op("and_n", OP_AND, 0, 0, 0, r, e); chk("and_n.const", r, 32'h0);
    run_op("or_n", OP_OR, 0, 0, 0, r, e);   chk("or_n.const", r, 32'h8007);
    run_op("xor_n", OP_XOR, 0, 0, 0, r, e); chk("xor_n.const", r, 32'h8007);
    load(0, 32'hFFFFFFFF);
    run_op("and_w", OP_AND, 1, 0, 0, r, e); chk("and_w.const", r, 32'hFFFFFFFF);

    load(0, 32'h00010000); load(1, 32'h0);
    run_op("mingle_ovf", OP_MINGLE, 0, 0, 0, r, e);
    chk("mingle_ovf.err", {31'b0, e}, 1);
    run_op("illegal", 3'b110, 0, 0, 0, r, e);
    chk("illegal.err_sticky", {31'b0, intf.err}, 1);
    run_op("clear_err", OP_OR, 1, 0, 0, r, e);
    chk("clear_err.err", {31'b0, intf.err}, 0);

    // start wins over a same-cycle load; A must stay untouched afterwards
    load(0, 32'h0000FFFF); load(1, 32'h0);
    intf.ld_a = 1'b1; intf.din = 8'h77;
    run_op("start_ld", OP_MINGLE, 0, 0, 0, r, e);
    run_op("start_ld_after", OP_OR, 1, 0, 0, r, e);

    load(0, 32'h12345678); load(1, 32'h0F0FF0F0);
    run_op("poke", OP_SELECT, 1, 0, 1, r, e);
    run_op("poke_after", OP_SELECT, 1, 0, 0, r, e);
    run_op("ena_gap", OP_SELECT, 1, 5, 0, r, e);

    // reset in the middle of a select
    load(0, 32'h12345678); load(1, 32'hFFFFFFFF);
    intf.op = OP_SELECT; intf.wide = 1'b1; intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_m = '0; b_m = '0;
    chk("rst_mid.busy", {31'b0, intf.busy}, 0);
    read_r(r);
    chk("rst_mid.r", r, 0);
    seen = 1'b0;
    repeat (40) begin
      if (intf.done) seen = 1'b1;
      tick();
    end
    chk("rst_mid.no_done", {31'b0, seen}, 0);
    run_op("rst_mid.a_zero", OP_OR, 1, 0, 0, r, e);
    load(0, 32'h0000BEEF); load(1, 32'h00001234);
    run_op("rst_mid.restart", OP_MINGLE, 0, 0, 0, r, e);

    for (int it = 0; it < 30; it++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF;
      if ($urandom_range(0, 1) == 1) rb = rb & 32'hFFFF;
      load(0, ra); load(1, rb);
      run_op($sformatf("rnd%0d", it), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0, r, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/intercal_alu_serial.md
# intercal_alu_serial

Parametrised, sequential successor to the single-shot INTERCAL ALU. It computes mingle (`$`), select (`~`) and the unary AND/OR/XOR rotate-and-combine operators. Width is set by a parameter, and each operation runs in narrow (W) or wide (2W) mode. Operands load byte-serially over an 8-bit bus, and results are read back through a byte mux, which fits the 8-bit pin budget of the tile wrapper. Select is bit-serial, and the block reports busy/done/error status.

## Interface
- `W`, default 16: narrow width. Wide width is 2W. W is a multiple of 8 and at least 8.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: when low, all state holds and inputs are ignored.
- `ld_a` in 1: shift `din` into operand A, `A <= {A[2W-9:0], din}`.
- `ld_b` in 1: same for operand B.
- `din` in 8: load byte, MSB byte first.
- `start` in 1: begin the operation given by `op`/`wide`.
- `op` in 3: 000 mingle, 001 select, 010 AND, 011 OR, 100 XOR, 101–111 illegal.
- `wide` in 1: 1 selects 2W-bit unary/select. Ignored for mingle.
- `out_sel` in log2(2W/8): result byte index, 0 is the LSB byte.
- `dout` out 8: combinational `R[8*out_sel +: 8]`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when R/err update.
- `err` out 1: sticky until next start. Set on illegal op or operand overflow.

## Operation
- States: IDLE, RUN, FIN.
- IDLE + start: latch op/wide, clear err, go to RUN with counter N.
  - N = 1 for mingle/unary/illegal.
  - N = W (narrow) or 2W (wide) for select.
- Mingle: `R[2i+1] = A[i]`, `R[2i] = B[i]` for i < W.
  - If `A[2W-1:W]` or `B[2W-1:W]` is nonzero: err=1, R=0.
- Select, MSB→LSB scan over n = W or 2W bits, one bit per RUN cycle:
  - if `B[i]`: `R <= {R[2W-2:0], A[i]}`.
  - R cleared at start. Result is right-justified, with bit order preserved.
- Unary on n bits: `R = A[n-1:0] op rotr(A[n-1:0], 1)`, zero-extended.
  - Narrow with `A[2W-1:W]` nonzero: err=1, R=0.
- Illegal op: err=1, R=0.
- RUN→FIN when the counter expires. FIN pulses done and returns to IDLE.
- R holds until the next start. A and B are never modified by operations.

## Timing
- Reset (rst_n low at a clk edge): A=B=R=0, busy=done=err=0, state IDLE.
  - Takes effect mid-operation with no result produced.
- Start sampled at edge t: busy=1 for cycles t+1..t+N. done=1 and busy=0 at t+N+1, with R/err valid from that cycle.
- Single-cycle ops: busy in cycle t+1, done in cycle t+2.
- start/ld_a/ld_b while busy or in FIN are ignored.
- start and ld_x in the same IDLE cycle: start wins, uses the old A/B, and the load is dropped.
- ld_a and ld_b together: both shift the same `din`.
- Back-to-back: start accepted in the cycle after done.
- `ena` low: counter, state and registers freeze. Outputs hold, and done stays high if it was high.

## Structure
- `intercal_alu_pkg`: opcode enum `op_t`, state enum, `OP_*` constants.
- Sub-module `intercal_select_serial`, parametrised on width:
  - inputs: A, B, wide, go.
  - outputs: R, last.
- Top holds operand shift registers, FSM, combinational mingle/unary, and dout mux.

## Test plan
- W=16, A=0x0000FFFF, B=0, mingle:
  - R=0xAAAAAAAA, err=0.
  - busy for 1 cycle, done 2 cycles after start.
- Select, wide, A=0xF0F0F0F0, B=0xFF00FF00:
  - R=0x0000F0F0.
  - busy exactly 32 cycles. Narrow with A=0x00F0, B=0x00FF gives R=0x00F0 in 16 cycles.
- Narrow unary, A=0x0005:
  - AND gives 0x0000.
  - OR gives 0x8007.
  - XOR gives 0x8007.
  - Wide AND of 0xFFFFFFFF gives 0xFFFFFFFF.
- Errors:
  - mingle with A=0x00010000 gives err=1, R=0.
  - op=110 gives err=1.
  - the next valid start clears err.
- Interference:
  - start+ld_a same cycle: the old A is used.
  - ld_b and start mid-select: ignored, result unchanged.
  - ena low for 5 cycles mid-select: latency extends by 5.
- rst_n low mid-select:
  - next cycle busy=0, R=0, A=0.
  - no done pulse.
  - a new start works normally.
